// File: rtl/qa_drv_memory.sv
// qa_drv_memory: direct-memory client on the driver's CCI shim mux memory port.
// Accepts cache-line read/write requests, issues CCI C0 RdLine / C1 WrLine
// requests under almost-full flow control, returns read data in request order
// through a tag-indexed reorder buffer, and tracks write acknowledgements.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_req_*                   read request (addr/en/rdy)
//   rd_rsp_*                   in-order read response (data/rdy/enable)
//   wr_req_*                   write request (addr/data/en/rdy)
//   wr_ack_count, wr_inflight  write ack count this cycle, writes outstanding
//   err_stray                  sticky flag for unexpected read responses
//   C0Tx*/C1Tx*/C0Rx*/C1Rx*    CCI transmit and receive channels
module qa_drv_memory #(
  parameter int unsigned CCI_DATA_WIDTH   = 512,
  parameter int unsigned CCI_RX_HDR_WIDTH = 18,
  parameter int unsigned CCI_TX_HDR_WIDTH = 61,
  parameter int unsigned CCI_TAG_WIDTH    = 13,
  parameter int unsigned MAX_READS        = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 rd_req_addr,
  input  logic                        rd_req_en,
  output logic                        rd_req_rdy,
  output logic [CCI_DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                        rd_rsp_rdy,
  input  logic                        rd_rsp_enable,
  input  logic [31:0]                 wr_req_addr,
  input  logic [CCI_DATA_WIDTH-1:0]   wr_req_data,
  input  logic                        wr_req_en,
  output logic                        wr_req_rdy,
  output logic [1:0]                  wr_ack_count,
  output logic [15:0]                 wr_inflight,
  output logic                        err_stray,
  output logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr,
  output logic                        C0TxRdValid,
  input  logic                        C0TxAlmFull,
  output logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   C1TxData,
  output logic                        C1TxWrValid,
  output logic                        C1TxIrValid,
  input  logic                        C1TxAlmFull,
  input  logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]   C0RxData,
  input  logic                        C0RxRdValid,
  input  logic                        C0RxWrValid,
  input  logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr,
  input  logic                        C1RxWrValid
);

  localparam int unsigned PTR_W    = $clog2(MAX_READS);
  localparam int unsigned TYPE_LSB = 52;
  localparam int unsigned ADDR_LSB = 14;
  localparam logic [3:0]  REQ_RDLINE = 4'h4;
  localparam logic [3:0]  REQ_WRLINE = 4'h2;

  // Extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]            head, tail, occupancy;
  logic [PTR_W-1:0]          head_idx, rsp_idx, rsp_offset;
  logic [MAX_READS-1:0]      valid;
  logic [CCI_DATA_WIDTH-1:0] buffer [MAX_READS];
  logic                      rd_accept, wr_accept, deq;
  logic                      rsp_in_window, rsp_accept, rsp_stray;
  logic [15:0]               inflight_next;
  logic [17:0]               inflight_sum;
  logic                      unused_hdr_bits;

  // The mux-owned tag bit and the channel 1 header carry nothing for us.
  assign unused_hdr_bits = ^{C1RxHdr, C0RxHdr[CCI_RX_HDR_WIDTH-1:PTR_W]};

  function automatic logic [CCI_TX_HDR_WIDTH-1:0] make_hdr(
    input logic [3:0]       req_type,
    input logic [31:0]      addr,
    input logic [PTR_W-1:0] tag
  );
    logic [CCI_TX_HDR_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[TYPE_LSB +: 4]  = req_type;
    hdr[ADDR_LSB +: 32] = addr;
    hdr[PTR_W-1:0]      = tag;
    return hdr;
  endfunction

  assign occupancy  = tail - head;
  assign head_idx   = head[PTR_W-1:0];
  assign rsp_idx    = C0RxHdr[PTR_W-1:0];
  // Distance of the response tag from head, modulo the buffer depth.
  assign rsp_offset = rsp_idx - head_idx;

  assign rsp_in_window = {1'b0, rsp_offset} < occupancy;
  assign rsp_accept    = C0RxRdValid && rsp_in_window && !valid[rsp_idx];
  assign rsp_stray     = C0RxRdValid && !rsp_accept;

  assign rd_req_rdy  = !reset && !C0TxAlmFull && (occupancy < (PTR_W+1)'(MAX_READS));
  assign rd_accept   = rd_req_en && rd_req_rdy;
  assign rd_rsp_rdy  = valid[head_idx];
  assign rd_rsp_data = buffer[head_idx];
  assign deq         = rd_rsp_rdy && rd_rsp_enable;

  assign wr_req_rdy  = !reset && !C1TxAlmFull;
  assign wr_accept   = wr_req_en && wr_req_rdy;
  assign C1TxIrValid = 1'b0;

  // Read request issue on channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      C0TxRdValid <= 1'b0;
      C0TxHdr     <= '0;
      tail        <= '0;
    end else begin
      C0TxRdValid <= rd_accept;
      if (rd_accept) begin
        C0TxHdr <= make_hdr(REQ_RDLINE, rd_req_addr, tail[PTR_W-1:0]);
        tail    <= tail + (PTR_W+1)'(1);
      end
    end
  end

  // Reorder control: head pointer, per-slot valid bits, stray detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      valid     <= '0;
      err_stray <= 1'b0;
    end else begin
      if (deq) begin
        valid[head_idx] <= 1'b0;
        head            <= head + (PTR_W+1)'(1);
      end
      if (rsp_accept) valid[rsp_idx] <= 1'b1;
      if (rsp_stray)  err_stray      <= 1'b1;
    end
  end

  // Reorder data storage.
  always_ff @(posedge clk) begin
    if (!reset && rsp_accept) buffer[rsp_idx] <= C0RxData;
  end

  // Net in-flight change; an 18-bit signed sum exposes under- and overflow.
  always_comb begin
    inflight_sum  = '0;
    inflight_next = wr_inflight;
    inflight_sum  = {2'b00, wr_inflight} + 18'(wr_accept)
                    - 18'(C0RxWrValid) - 18'(C1RxWrValid);
    if (inflight_sum[17])      inflight_next = 16'h0000;
    else if (inflight_sum[16]) inflight_next = 16'hFFFF;
    else                       inflight_next = inflight_sum[15:0];
  end

  // Write request issue on channel 1 and ack accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      C1TxWrValid  <= 1'b0;
      C1TxHdr      <= '0;
      C1TxData     <= '0;
      wr_ack_count <= 2'd0;
      wr_inflight  <= 16'd0;
    end else begin
      C1TxWrValid  <= wr_accept;
      if (wr_accept) begin
        C1TxHdr  <= make_hdr(REQ_WRLINE, wr_req_addr, '0);
        C1TxData <= wr_req_data;
      end
      wr_ack_count <= 2'(C0RxWrValid) + 2'(C1RxWrValid);
      wr_inflight  <= inflight_next;
    end
  end

endmodule
